pc_sequencer: RTL and testbench

- Fetch-sequencing controller for the variable-width program counter.
- Owns the PC's load/inc/in controls and runs the instruction-fetch handshake toward instruction memory.
- Arbitrates next-PC sources: reset vector, sequential increment, branch, interrupt entry/return, and an optional hardware return-address stack.
- Sits between the decoder/interrupt logic and the PC register; the PC output feeds back as pc_value.

---
 rtl/pc_sequencer.sv | 184 ++++++++++++++++++
 tb/tb_pc_sequencer.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch handshake and next-PC arbitration (reset, inc, branch, irq entry/return).
// Defining PC_SEQ_RAS_EN adds a circular hardware return-address stack for call/ret.
module pc_sequencer #(
  parameter int          DATA_SIZE    = 16,
  parameter int unsigned RESET_VECTOR = 0,
  parameter int unsigned IRQ_VECTOR   = 4,
  parameter int          RAS_DEPTH    = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [DATA_SIZE-1:0] pc_value,
  output logic [DATA_SIZE-1:0] pc_in,
  output logic                 pc_load,
  output logic                 pc_inc,
  output logic                 fetch_req,
  output logic [DATA_SIZE-1:0] fetch_addr,
  input  logic                 fetch_ack,
  input  logic                 stall,
  input  logic                 halt,
  output logic                 halted,
  input  logic                 branch_valid,
  input  logic [DATA_SIZE-1:0] branch_target,
  input  logic                 call,
  input  logic                 ret,
  input  logic                 irq,
  input  logic                 iret,
  output logic                 irq_ack,
  output logic [DATA_SIZE-1:0] epc,
  output logic                 ras_err
);

  localparam logic [DATA_SIZE-1:0] RST_VEC = DATA_SIZE'(RESET_VECTOR);
  localparam logic [DATA_SIZE-1:0] IRQ_VEC = DATA_SIZE'(IRQ_VECTOR);

  if (RAS_DEPTH < 2 || (RAS_DEPTH & (RAS_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("pc_sequencer: RAS_DEPTH must be a power of 2 and at least 2");
  end

  typedef enum logic [1:0] {BOOT, REQ, UPD, HALTED} state_t;

  state_t               state, state_nxt;
  logic [DATA_SIZE-1:0] epc_q;
  logic                 in_handler;
  logic [DATA_SIZE-1:0] pc_plus1;
  logic                 take_irq, take_iret;
  logic                 ras_push, ras_pop, ras_fault;

  assign pc_plus1   = pc_value + 1'b1;
  assign fetch_addr = pc_value;
  assign epc        = epc_q;

`ifdef PC_SEQ_RAS_EN
  localparam int RAS_AW = $clog2(RAS_DEPTH);
  localparam logic [RAS_AW:0] RAS_FULL = (RAS_AW + 1)'(RAS_DEPTH);

  logic [DATA_SIZE-1:0] ras_mem [RAS_DEPTH];
  logic [RAS_AW-1:0]    ras_top;   // next slot to write; top entry sits just below
  logic [RAS_AW:0]      ras_cnt;
  logic                 ras_err_q;
  logic                 ras_empty, ras_full;

  assign ras_empty = (ras_cnt == '0);
  assign ras_full  = (ras_cnt == RAS_FULL);
  assign ras_err   = ras_err_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ras_top   <= '0;
      ras_cnt   <= '0;
      ras_err_q <= 1'b0;
    end else begin
      if (ras_push) begin
        ras_top <= ras_top + 1'b1;
        if (!ras_full) ras_cnt <= ras_cnt + 1'b1;
      end else if (ras_pop) begin
        ras_top <= ras_top - 1'b1;
        ras_cnt <= ras_cnt - 1'b1;
      end
      if (ras_fault) ras_err_q <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (ras_push) ras_mem[ras_top] <= pc_plus1;
  end
`else
  logic unused_ras_inputs;
  assign unused_ras_inputs = call | ret | ras_push | ras_pop | ras_fault;
  assign ras_err = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    pc_load   = 1'b0;
    pc_inc    = 1'b0;
    pc_in     = '0;
    fetch_req = 1'b0;
    irq_ack   = 1'b0;
    halted    = 1'b0;
    take_irq  = 1'b0;
    take_iret = 1'b0;
    ras_push  = 1'b0;
    ras_pop   = 1'b0;
    ras_fault = 1'b0;
    // Outputs are held quiet for the whole reset window, even though state already reads BOOT.
    if (!reset) begin
      case (state)
        BOOT: begin
          pc_load   = 1'b1;
          pc_in     = RST_VEC;
          state_nxt = UPD;
        end
        UPD: state_nxt = REQ;
        HALTED: begin
          halted = 1'b1;
          if (!halt || irq) state_nxt = REQ;
        end
        default: begin
          fetch_req = !stall && !halt;
          if (halt) begin
            state_nxt = HALTED;
          end else if (fetch_req && fetch_ack) begin
            state_nxt = UPD;
            if (irq && !in_handler) begin
              take_irq = 1'b1;
              pc_load  = 1'b1;
              pc_in    = IRQ_VEC;
              irq_ack  = 1'b1;
            end else if (iret) begin
              if (in_handler) begin
                take_iret = 1'b1;
                pc_load   = 1'b1;
                pc_in     = epc_q;
              end else begin
                pc_inc = 1'b1;
              end
`ifdef PC_SEQ_RAS_EN
            end else if (ret) begin
              if (!ras_empty) begin
                ras_pop = 1'b1;
                pc_load = 1'b1;
                pc_in   = ras_mem[ras_top - 1'b1];
              end else begin
                ras_fault = 1'b1;
                pc_inc    = 1'b1;
              end
            end else if (branch_valid) begin
              pc_load = 1'b1;
              pc_in   = branch_target;
              if (call) begin
                ras_push  = 1'b1;
                ras_fault = ras_full;
              end
`else
            end else if (branch_valid) begin
              pc_load = 1'b1;
              pc_in   = branch_target;
`endif
            end else begin
              pc_inc = 1'b1;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= BOOT;
      epc_q      <= '0;
      in_handler <= 1'b0;
    end else begin
      state <= state_nxt;
      if (take_irq) begin
        epc_q      <= pc_plus1;
        in_handler <= 1'b1;
      end else if (take_iret) begin
        in_handler <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed walk through the fetch/redirect scenarios, then random traffic vs a behavioural model.
module tb_pc_sequencer;

  localparam logic [15:0] RV    = 16'h0100;
  localparam logic [15:0] IV    = 16'h0004;
  localparam int          DEPTH = 4;
`ifdef PC_SEQ_RAS_EN
  localparam bit RAS_ON = 1'b1;
`else
  localparam bit RAS_ON = 1'b0;
`endif

  localparam int P_BOOT = 0, P_UPD = 1, P_REQ = 2, P_HALT = 3;

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] pc_value, pc_in, fetch_addr, branch_target, epc;
  logic        pc_load, pc_inc, fetch_req, fetch_ack, stall, halt, halted;
  logic        branch_valid, call, ret, irq, iret, irq_ack, ras_err;

  pc_sequencer #(
    .DATA_SIZE(16), .RESET_VECTOR(32'h0100), .IRQ_VECTOR(32'h0004), .RAS_DEPTH(DEPTH)
  ) dut (
    .clock(clock), .reset(reset), .pc_value(pc_value), .pc_in(pc_in),
    .pc_load(pc_load), .pc_inc(pc_inc), .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .fetch_ack(fetch_ack), .stall(stall), .halt(halt), .halted(halted),
    .branch_valid(branch_valid), .branch_target(branch_target), .call(call), .ret(ret),
    .irq(irq), .iret(iret), .irq_ack(irq_ack), .epc(epc), .ras_err(ras_err)
  );

  always #5 clock = ~clock;

  // The PC register the sequencer drives.
  logic [15:0] pc_reg = 16'h0000;
  always @(posedge clock) begin
    if (pc_load)     pc_reg <= pc_in;
    else if (pc_inc) pc_reg <= pc_reg + 16'h0001;
  end
  assign pc_value = pc_reg;

  // Behavioural model state.
  int          ph;
  logic [15:0] m_epc;
  bit          m_inh, m_err;
  logic [15:0] ras_q[$];

  typedef struct {
    bit          load, inc, req, iack, halted, err;
    logic [15:0] in_v, epc, push_val, new_epc;
    int          nph;
    bit          irq_take, iret_take, push, pop, fault;
  } exp_t;
  exp_t e;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, got, want, $time);
    end
  endtask

  task automatic m_reset();
    ph    = P_BOOT;
    m_epc = 16'h0;
    m_inh = 1'b0;
    m_err = 1'b0;
    ras_q.delete();
  endtask

  function automatic exp_t predict();
    exp_t x;
    x = '{default: 0};
    x.nph = ph;
    x.epc = m_epc;
    x.err = m_err;
    if (reset) begin
      x.epc = 16'h0;
      x.err = 1'b0;
      return x;
    end
    case (ph)
      P_BOOT: begin x.load = 1; x.in_v = RV; x.nph = P_UPD; end
      P_UPD:  x.nph = P_REQ;
      P_HALT: begin x.halted = 1; if (!halt || irq) x.nph = P_REQ; end
      default: begin
        x.req = !stall && !halt;
        if (halt) x.nph = P_HALT;
        else if (x.req && fetch_ack) begin
          x.nph = P_UPD;
          if (irq && !m_inh) begin
            x.load = 1; x.in_v = IV; x.iack = 1; x.irq_take = 1; x.new_epc = pc_reg + 16'h1;
          end else if (iret) begin
            if (m_inh) begin x.load = 1; x.in_v = m_epc; x.iret_take = 1; end
            else x.inc = 1;
          end else if (RAS_ON && ret) begin
            if (ras_q.size() > 0) begin x.load = 1; x.in_v = ras_q[$]; x.pop = 1; end
            else begin x.inc = 1; x.fault = 1; end
          end else if (branch_valid) begin
            x.load = 1; x.in_v = branch_target;
            if (RAS_ON && call) begin x.push = 1; x.push_val = pc_reg + 16'h1; end
          end else x.inc = 1;
        end
      end
    endcase
    return x;
  endfunction

  task automatic commit();
    if (reset) begin
      m_reset();
      return;
    end
    ph = e.nph;
    if (e.irq_take)  begin m_epc = e.new_epc; m_inh = 1'b1; end
    if (e.iret_take) m_inh = 1'b0;
    if (e.pop)       void'(ras_q.pop_back());
    if (e.push) begin
      if (ras_q.size() == DEPTH) begin void'(ras_q.pop_front()); m_err = 1'b1; end
      ras_q.push_back(e.push_val);
    end
    if (e.fault) m_err = 1'b1;
  endtask

  task automatic to_neg();
    @(negedge clock);
    e = predict();
    chk("pc_load",    pc_load,    e.load);
    chk("pc_inc",     pc_inc,     e.inc);
    chk("pc_in",      pc_in,      e.in_v);
    chk("fetch_req",  fetch_req,  e.req);
    chk("fetch_addr", fetch_addr, pc_reg);
    chk("irq_ack",    irq_ack,    e.iack);
    chk("halted",     halted,     e.halted);
    chk("epc",        epc,        e.epc);
    chk("ras_err",    ras_err,    e.err);
  endtask

  task automatic to_pos();
    @(posedge clock);
    commit();
    #1;
  endtask

  task automatic cyc();
    to_neg();
    to_pos();
  endtask

  initial begin
    {fetch_ack, stall, halt, branch_valid, call, ret, irq, iret} = '0;
    branch_target = 16'h0;
    reset = 1'b1;
    m_reset();
    to_neg();
    chk("rst_load", pc_load, 0); chk("rst_req", fetch_req, 0); chk("rst_halted", halted, 0);
    chk("rst_epc", epc, 0); chk("rst_err", ras_err, 0); chk("rst_in", pc_in, 0);
    to_pos();
    cyc();
    reset = 1'b0;

    to_neg(); chk("boot_load", pc_load, 1); chk("boot_in", pc_in, 16'h0100); to_pos();
    to_neg(); chk("upd_noreq", fetch_req, 0); to_pos();
    fetch_ack = 1'b1;
    for (int i = 0; i < 5; i++) begin
      to_neg(); chk("seq_req", fetch_req, 1); chk("seq_addr", fetch_addr, 16'h0100 + 16'(i));
      chk("seq_inc", pc_inc, 1); to_pos();
      cyc();
    end

    // pc = 0x0105: irq beats a simultaneous branch.
    branch_valid = 1'b1; branch_target = 16'h0040; irq = 1'b1;
    to_neg(); chk("irq_in", pc_in, 16'h0004); chk("irq_ack", irq_ack, 1); to_pos();
    branch_valid = 1'b0; irq = 1'b0;
    to_neg(); chk("irq_epc", epc, 16'h0106); chk("irq_ack_pulse", irq_ack, 0); to_pos();
    iret = 1'b1;
    to_neg(); chk("iret_load", pc_load, 1); chk("iret_in", pc_in, 16'h0106); to_pos();
    iret = 1'b0;
    cyc();

    stall = 1'b1;
    to_neg(); chk("stall_req", fetch_req, 0); chk("stall_cmd", pc_load | pc_inc, 0); to_pos();
    stall = 1'b0; halt = 1'b1;
    to_neg(); chk("halt_req", fetch_req, 0); to_pos();
    to_neg(); chk("halted", halted, 1); to_pos();
    irq = 1'b1;
    to_neg(); chk("halted_irq", halted, 1); to_pos();
    irq = 1'b0;
    to_neg(); chk("irq_wake", halted, 0); to_pos();
    halt = 1'b0;
    to_neg(); chk("halt_wait", halted, 1); to_pos();

    // Interrupt taken at 0xFFFF: return address wraps.
    branch_valid = 1'b1; branch_target = 16'hFFFF;
    to_neg(); chk("br_in", pc_in, 16'hFFFF); to_pos();
    branch_valid = 1'b0;
    cyc();
    irq = 1'b1;
    to_neg(); chk("wrap_addr", fetch_addr, 16'hFFFF); to_pos();
    irq = 1'b0;
    to_neg(); chk("wrap_epc", epc, 16'h0000); to_pos();
    iret = 1'b1;
    to_neg(); chk("wrap_iret_load", pc_load, 1); chk("wrap_iret_in", pc_in, 16'h0000); to_pos();
    iret = 1'b0;
    cyc();

    // Five nested calls from pc 0, then five returns.
    branch_valid = 1'b1; call = 1'b1;
    for (int i = 0; i < 5; i++) begin
      branch_target = 16'h0200 + 16'(i * 16);
      to_neg(); chk("call_in", pc_in, 16'h0200 + 16'(i * 16)); to_pos();
      cyc();
    end
    branch_valid = 1'b0; call = 1'b0; ret = 1'b1;
    for (int i = 0; i < 4; i++) begin
      to_neg(); chk("ret_load", pc_load, RAS_ON);
      chk("ret_in", pc_in, RAS_ON ? 16'h0231 - 16'(i * 16) : 16'h0000); to_pos();
      cyc();
    end
    to_neg(); chk("ret_under_inc", pc_inc, 1); chk("ret_under_err", ras_err, RAS_ON); to_pos();
    ret = 1'b0;
    to_neg(); chk("ras_err_sticky", ras_err, RAS_ON); to_pos();

    // Reset landing in UPD right after a branch.
    branch_valid = 1'b1; branch_target = 16'h0300;
    to_neg(); to_pos();
    branch_valid = 1'b0; reset = 1'b1;
    m_reset();
    to_neg();
    chk("mid_load", pc_load, 0); chk("mid_inc", pc_inc, 0); chk("mid_req", fetch_req, 0);
    chk("mid_iack", irq_ack, 0); chk("mid_halted", halted, 0); chk("mid_err", ras_err, 0);
    chk("mid_epc", epc, 0); chk("mid_in", pc_in, 0);
    to_pos();
    reset = 1'b0;
    to_neg(); chk("reboot_load", pc_load, 1); chk("reboot_in", pc_in, 16'h0100); to_pos();

    for (int i = 0; i < 3000; i++) begin
      fetch_ack     = ($urandom_range(3) != 0);
      stall         = ($urandom_range(7) == 0);
      halt          = ($urandom_range(15) == 0);
      branch_valid  = ($urandom_range(2) == 0);
      branch_target = 16'($urandom);
      call          = $urandom_range(1) == 1;
      ret           = ($urandom_range(3) == 0);
      irq           = ($urandom_range(7) == 0);
      iret          = ($urandom_range(3) == 0);
      if ($urandom_range(299) == 0) begin
        reset = 1'b1;
        m_reset();
      end else begin
        reset = 1'b0;
      end
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
